alpu_cache_rd_arbiter: RTL and testbench
========================================

Name: alpu_cache_rd_arbiter

Overview:
- Round-robin arbiter and sequencer for the single interconnect read port (r0) of an exec unit's ALPU cache.
- Accepts read requests from NUM_REQ foreign exec units, serialises them onto the cache port and captures the returned operand.
- Returns the operand to the granted requester; a bounded lookup timeout reports misses so requesters never hang.

Parameters:
- NUM_REQ, 4, number of requesting exec units (2..8).
- ADDR_WIDTH, 8, width of a local exec-unit operand address.
- DATA_WIDTH, 16, width of exec-unit operand data.
- MAX_WAIT, 7, cycles to hold a lookup without cache valid before reporting a miss (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester read address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot; request i accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot response valid to the granted requester.
- rsp_data  out  DATA_WIDTH  response data, shared by all requesters.
- rsp_miss  out  1  qualifies rsp_valid; 1 means timeout, rsp_data = 0.
- rsp_ready  in  NUM_REQ  per-requester response ready.
- icon_r0addr  out  ADDR_WIDTH  address to cache read port.
- icon_r0ready  out  1  lookup strobe to cache; data transferred when icon_r0valid & icon_r0ready.
- icon_r0data  in  DATA_WIDTH  cache read data.
- icon_r0valid  in  1  cache read hit/data valid.

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset tree):
  - state = IDLE, rr_ptr = 0, wait_cnt = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_miss, rsp_data, icon_r0addr, icon_r0ready.
  - Reset mid-transaction drops the transaction; no response is issued.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - Combinationally select the first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ.
  - Assert req_ready[i] for that i only.
  - On accept: register grant index g and req_addr[g]; wait_cnt = 0; go to LOOKUP next cycle.
  - No request: stay in IDLE, req_ready = 0.
- LOOKUP:
  - icon_r0addr = registered address; icon_r0ready = 1; req_ready = 0.
  - If icon_r0valid: capture icon_r0data into rsp_data, rsp_miss = 0, go to RESP.
  - Else wait_cnt++. When wait_cnt reaches MAX_WAIT with no valid: rsp_data = 0, rsp_miss = 1, go to RESP.
  - Minimum lookup latency 1 cycle, maximum MAX_WAIT+1 cycles. A valid that arrives in the same cycle as the timeout wins, giving a hit.
- RESP:
  - rsp_valid[g] = 1; rsp_data and rsp_miss are held stable.
  - icon_r0ready = 0; icon_r0addr holds its last value.
  - On rsp_ready[g]: rsp_valid goes to 0, rr_ptr = (g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready on non-granted lines is ignored.
- Throughput: at most 1 transaction per 3 cycles (accept, lookup, response). The block has no pipelining and at most one outstanding transaction.
- Fairness: any continuously asserted requester is granted within NUM_REQ transactions. rr_ptr advances only on response completion; it wraps from NUM_REQ-1 to 0.
- Handshake rules:
  - Requesters must hold req_valid and req_addr until accepted. Dropping req_valid before accept is legal; the request is simply not granted.
  - req_addr of non-granted requesters may change freely.
- Assertions the verification engineer must check:
  - req_ready and rsp_valid are each at most one-hot.
  - icon_r0ready is high only in LOOKUP.
  - rsp_miss is never 1 without a rsp_valid bit set.

Test Plan:
- Single hit: req_valid=0001, req_addr[0]=0x12; cache returns valid with data 0xBEEF one cycle after strobe -> req_ready=0001 in the accept cycle, icon_r0addr=0x12, rsp_valid=0001 with rsp_data=0xBEEF, rsp_miss=0; 3 cycles total with rsp_ready tied high.
- Round-robin: all four requesters hold req_valid with addresses 0x10..0x13; cache always hits -> grant order 0,1,2,3,0; icon_r0addr sequence 0x10,0x11,0x12,0x13,0x10.
- Miss timeout: MAX_WAIT=7, icon_r0valid held 0 -> icon_r0ready stays high for exactly 8 cycles, then rsp_valid[g]=1, rsp_miss=1, rsp_data=0.
- Late hit at boundary: icon_r0valid asserted in the 8th lookup cycle with data 0x00AA -> rsp_miss=0, rsp_data=0x00AA.
- Response backpressure: rsp_ready[2] held low for 5 cycles while req_valid=1111 -> rsp_valid=0100 and rsp_data stay stable, req_ready=0; after rsp_ready[2]=1, the next grant goes to requester 3.
- Reset mid-LOOKUP: assert reset during lookup -> all outputs 0 immediately (asynchronously); after release, rr_ptr=0, and a pending request from requester 2 is granted in the first IDLE cycle with no stale response.

Source files
------------

// File: rtl/alpu_cache_rd_arbiter.sv
// Round-robin read arbiter for the ALPU cache interconnect port r0.
// Serialises one foreign read at a time and reports a miss after a bounded lookup.
module alpu_cache_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_miss,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [ADDR_WIDTH-1:0]         icon_r0addr,
  output logic                          icon_r0ready,
  input  logic [DATA_WIDTH-1:0]         icon_r0data,
  input  logic                          icon_r0valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr, grant_idx, sel_idx;
  logic                   sel_found;
  logic [IDX_W:0]         cand;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CNT_W-1:0]       wait_cnt;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   miss_q;
  logic                   accept, hit, timeout, done;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!sel_found && req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    icon_r0ready = 1'b0;
    accept       = 1'b0;
    hit          = 1'b0;
    timeout      = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no grant is offered while the block is held in reset.
        if (sel_found && !reset) begin
          req_ready[sel_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = LOOKUP;
        end
      end
      LOOKUP: begin
        icon_r0ready = 1'b1;
        if (icon_r0valid) begin
          hit       = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == MAX_WAIT_C) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant_idx]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[grant_idx] = 1'b1;
  end

  assign rsp_miss    = (state == RESP) && miss_q;
  assign rsp_data    = data_q;
  assign icon_r0addr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      addr_q    <= '0;
      wait_cnt  <= '0;
      data_q    <= '0;
      miss_q    <= 1'b0;
    end else begin
      if (accept) begin
        grant_idx <= sel_idx;
        addr_q    <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wait_cnt  <= '0;
        miss_q    <= 1'b0;
      end
      if (state == LOOKUP && !hit && !timeout) wait_cnt <= wait_cnt + CNT_W'(1);
      if (hit) begin
        data_q <= icon_r0data;
        miss_q <= 1'b0;
      end
      if (timeout) begin
        data_q <= '0;
        miss_q <= 1'b1;
      end
      // Pointer moves past the served requester only once its response completes.
      if (done) rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_alpu_cache_rd_arbiter.sv
// Scoreboard bench for alpu_cache_rd_arbiter: random requesters and cache latency
// against a round-robin reference model, plus directed corner cases.
module tb_alpu_cache_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MW = 7;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_miss;
  logic [N-1:0]    rsp_ready;
  logic [AW-1:0]   icon_r0addr;
  logic            icon_r0ready;
  logic [DW-1:0]   icon_r0data;
  logic            icon_r0valid;

  alpu_cache_rd_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_miss(rsp_miss),
    .rsp_ready(rsp_ready),
    .icon_r0addr(icon_r0addr), .icon_r0ready(icon_r0ready),
    .icon_r0data(icon_r0data), .icon_r0valid(icon_r0valid)
  );

  typedef struct {
    int          grant;
    logic [15:0] data;
    logic        miss;
    int          lookup_len;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  logic [AW-1:0] addr_log[$];

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit  busy = 0;
  int  rr = 0;
  bit  done_seen = 0;
  int  done_g = 0;
  int  delay_mode = 0;
  int  cache_delay = 0;
  int  last_len = 0;
  bit  drv_random = 0;
  bit  rsp_random = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] cacheMem(input logic [7:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  function automatic logic [N-1:0] oneHot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkTrue(input string name, input logic cond);
    checkOutput(name, {31'd0, cond}, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    checkOutput({tag, "_rsp_miss"}, 32'(rsp_miss), 0);
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 0);
    checkOutput({tag, "_r0addr"}, 32'(icon_r0addr), 0);
    checkOutput({tag, "_r0ready"}, 32'(icon_r0ready), 0);
  endtask

  // Reference model: round-robin grant from the bench's own pointer, expected
  // response pushed on acceptance, state updated on the clock edge.
  initial begin
    logic [N-1:0] exp_ready;
    int           exp_g;
    bit           pend_acc;
    logic [AW-1:0] pend_addr;
    int           d;
    exp_t         e;
    pend_acc = 0;
    exp_g = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0;
        rr = 0;
        done_seen = 0;
        exp_q.delete();
        pend_acc = 0;
      end else begin
        exp_ready = '0;
        if (!busy) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (req_valid[idx] && exp_ready == '0) begin
              exp_ready[idx] = 1'b1;
              exp_g = idx;
            end
          end
        end
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        pend_acc = (exp_ready != '0);
        if (pend_acc) pend_addr = req_addr[exp_g*AW +: AW];
      end
      @(posedge clk);
      if (!reset) begin
        if (done_seen) begin
          busy = 0;
          rr = (done_g + 1) % N;
          done_seen = 0;
        end
        if (pend_acc) begin
          d = (delay_mode < 0) ? $urandom_range(0, MW + 2) : delay_mode;
          e.grant      = exp_g;
          e.miss       = (d > MW);
          e.data       = e.miss ? 16'h0000 : cacheMem(pend_addr);
          e.lookup_len = e.miss ? MW + 1 : d + 1;
          exp_q.push_back(e);
          grant_log.push_back(exp_g);
          cache_delay = d;
          busy = 1;
        end
      end
      pend_acc = 0;
    end
  end

  // Cache model: answers on the lookup cycle chosen for this transaction.
  initial begin
    int lookup_cnt;
    lookup_cnt = 0;
    icon_r0valid = 0;
    icon_r0data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        lookup_cnt = 0;
        icon_r0valid = 0;
      end else if (icon_r0ready) begin
        lookup_cnt++;
        if (lookup_cnt == 1) addr_log.push_back(icon_r0addr);
        icon_r0valid = (lookup_cnt == cache_delay + 1);
        icon_r0data  = icon_r0valid ? cacheMem(icon_r0addr) : 16'($urandom);
      end else begin
        if (lookup_cnt != 0) last_len = lookup_cnt;
        lookup_cnt = 0;
        icon_r0valid = 1'($urandom);
        icon_r0data  = 16'($urandom);
      end
    end
  end

  // Random requester / response-ready driver.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = reset ? '0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      if (drv_random) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && !acc[i]) begin
            if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
          end else begin
            req_valid[i] = ($urandom_range(0, 99) < 60);
            req_addr[i*AW +: AW] = AW'($urandom);
          end
        end
      end
      if (rsp_random) rsp_ready = N'($urandom_range(0, 15));
    end
  end

  // Monitor: pops the scoreboard when a response appears and holds it stable.
  initial begin
    bit            in_resp;
    int            cur_g;
    logic [N-1:0]  hold_valid;
    logic [DW-1:0] hold_data;
    logic          hold_miss;
    exp_t          e;
    in_resp = 0;
    cur_g = 0;
    hold_valid = '0;
    hold_data = '0;
    hold_miss = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_resp = 0;
        continue;
      end
      checkTrue("rsp_valid_onehot", $countones(rsp_valid) <= 1);
      checkTrue("miss_qualified", !(rsp_miss && rsp_valid == '0));
      checkTrue("r0ready_lookup_only", !(icon_r0ready && (rsp_valid != '0 || req_ready != '0)));
      if (rsp_valid != '0) begin
        if (!in_resp) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_rsp actual=%0h required=none", rsp_valid);
          end else begin
            e = exp_q.pop_front();
            checkOutput("rsp_grant", 32'(rsp_valid), 32'(oneHot(e.grant)));
            checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
            checkOutput("rsp_miss", 32'(rsp_miss), 32'(e.miss));
            checkOutput("lookup_len", 32'(last_len), 32'(e.lookup_len));
            hold_valid = rsp_valid;
            hold_data = rsp_data;
            hold_miss = rsp_miss;
            cur_g = e.grant;
            in_resp = 1;
          end
        end else begin
          checkOutput("hold_valid", 32'(rsp_valid), 32'(hold_valid));
          checkOutput("hold_data", 32'(rsp_data), 32'(hold_data));
          checkOutput("hold_miss", 32'(rsp_miss), 32'(hold_miss));
        end
        if (in_resp && rsp_valid[cur_g] && rsp_ready[cur_g]) begin
          in_resp = 0;
          done_seen = 1;
          done_g = cur_g;
        end
      end else if (in_resp) begin
        checkOutput("rsp_dropped", 32'(rsp_valid), 32'(hold_valid));
        in_resp = 0;
      end
    end
  end

  task automatic waitIdle(input int bound);
    for (int c = 0; c < bound && (busy || exp_q.size() != 0); c++) begin
      @(posedge clk);
      #1;
    end
    checkTrue("idle_reached", !busy && exp_q.size() == 0);
  endtask

  task automatic waitGrants(input int target, input int bound);
    for (int c = 0; c < bound && grant_log.size() < target; c++) begin
      @(posedge clk);
      #1;
    end
    checkTrue("grant_reached", grant_log.size() >= target);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  // One directed transaction from a single requester with a forced cache latency.
  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input int dly);
    int n;
    @(posedge clk);
    #1;
    delay_mode = dly;
    rsp_ready = '1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_addr[idx*AW +: AW] = addr;
    n = grant_log.size();
    waitGrants(n + 1, 20);
    req_valid = '0;
    waitIdle(40);
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    reset = 1;
    req_valid = '1;
    req_addr = '0;
    rsp_ready = '1;
    #1;
    checkResetOutputs("init");
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    reset = 0;

    $display("[TB] single hit");
    applyStimulus(0, 8'h12, 0);
    checkOutput("single_addr", 32'(addr_log[addr_log.size()-1]), 32'h12);

    $display("[TB] miss timeout and boundary hit");
    applyStimulus(1, 8'h5C, MW + 1);
    applyStimulus(3, 8'hC3, MW);
    applyStimulus(2, 8'h07, 3);

    $display("[TB] round robin");
    applyReset();
    grant_log.delete();
    addr_log.delete();
    delay_mode = 0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(8'h10 + i);
    req_valid = '1;
    waitGrants(5, 60);
    req_valid = '0;
    waitIdle(40);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr_grant", 32'(grant_log[i]), 32'(i % N));
      exp_addr = AW'(8'h10 + (i % N));
      checkOutput("rr_addr", 32'(addr_log[i]), 32'(exp_addr));
    end

    $display("[TB] response backpressure");
    applyReset();
    grant_log.delete();
    rsp_ready = 4'b1011;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(8'h20 + i);
    req_valid = '1;
    for (int c = 0; c < 40 && !rsp_valid[2]; c++) @(negedge clk);
    checkOutput("bp_reached", 32'(rsp_valid), 32'(4'b0100));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
      checkOutput("bp_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = '1;
    waitGrants(4, 20);
    req_valid = '0;
    if (grant_log.size() >= 4) checkOutput("bp_next_grant", 32'(grant_log[3]), 3);
    waitIdle(40);

    $display("[TB] reset during lookup");
    @(posedge clk);
    #1;
    delay_mode = MW + 1;
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 8'h33;
    for (int c = 0; c < 20 && !icon_r0ready; c++) begin
      @(posedge clk);
      #1;
    end
    checkTrue("lookup_started", icon_r0ready);
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 8'h44;
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    checkResetOutputs("midreset");
    delay_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    checkOutput("post_reset_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    req_valid = '0;
    waitIdle(40);

    $display("[TB] random traffic");
    delay_mode = -1;
    drv_random = 1;
    rsp_random = 1;
    repeat (3000) @(posedge clk);
    #2;
    drv_random = 0;
    rsp_random = 0;
    req_valid = '0;
    rsp_ready = '1;
    waitIdle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
